// File: rtl/dcache_multi_hart_bridge_pkg.sv
// Shared types for the multi-hart dcache bridge: request payload, memory op
// encoding, exception payload and the hart index width helper.
package muntjac_bridge_pkg;

    typedef enum logic [2:0] {
        MEM_LOAD  = 3'd0,
        MEM_STORE = 3'd1,
        MEM_LR    = 3'd2,
        MEM_SC    = 3'd3,
        MEM_AMO   = 3'd4
    } mem_op_e;

    typedef struct packed {
        logic [3:0]  cause;
        logic [63:0] tval;
    } exception_t;

    typedef struct packed {
        logic [63:0] address;
        logic [63:0] value;
        mem_op_e     op;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [6:0]  amo;
        logic        prv;
        logic        sum;
        logic        mxr;
        logic [63:0] atp;
    } dcache_bridge_req_t;

    // A single hart still needs a one-bit index so ports never collapse to zero width.
    function automatic int hart_idx_width(input int num_harts);
        return (num_harts > 1) ? $clog2(num_harts) : 1;
    endfunction

endpackage

// File: rtl/dcache_multi_hart_bridge_tag_fifo.sv
// In-order tag FIFO remembering which hart issued each outstanding request.
// DEPTH must be a power of two so the pointers wrap naturally.
module bridge_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage is write-only on push; contents are don't-care until pushed.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and count; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dcache_multi_hart_bridge.sv
// Merges NUM_HARTS dcache request channels onto one harness memory port with
// round-robin arbitration and a registered request stage, and routes in-order
// completions back to the issuing hart.
// Optional: define MUNTJAC_BRIDGE_PERF_EN to add per-hart accepted-request
// counters on perf_req_count_o.
module dcache_multi_hart_bridge
    import muntjac_bridge_pkg::*;
#(
    parameter int NUM_HARTS       = 2,
    parameter int MAX_OUTSTANDING = 4,
    localparam int HART_W = hart_idx_width(NUM_HARTS),
    localparam int OCC_W  = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_HARTS-1:0]                  h_req_valid_i,
    output logic [NUM_HARTS-1:0]                  h_req_ready_o,
    input  dcache_bridge_req_t [NUM_HARTS-1:0]    h_req_i,
    output logic [NUM_HARTS-1:0]                  h_resp_valid_o,
    output logic [NUM_HARTS-1:0]                  h_ex_valid_o,
    output logic [63:0]                           h_resp_value_o,
    output exception_t                            h_ex_exception_o,
    output logic                                  mem_req_valid_o,
    input  logic                                  mem_req_ready_i,
    output dcache_bridge_req_t                    mem_req_o,
    output logic [HART_W-1:0]                     mem_req_hart_o,
    input  logic                                  mem_resp_valid_i,
    input  logic [63:0]                           mem_resp_value_i,
    input  logic                                  mem_ex_valid_i,
    input  exception_t                            mem_ex_exception_i,
    output logic [OCC_W-1:0]                      occupancy_o,
    output logic                                  err_spurious_o
`ifdef MUNTJAC_BRIDGE_PERF_EN
    ,
    output logic [NUM_HARTS-1:0][31:0]            perf_req_count_o
`endif
);

    logic [HART_W-1:0]  r_ptr;
    logic               r_stage_valid;
    dcache_bridge_req_t r_stage_req;
    logic [HART_W-1:0]  r_stage_hart;
    logic               r_err_spurious;

    logic [HART_W-1:0]  w_grant;
    logic [HART_W-1:0]  w_idx;
    logic               w_found;
    logic               w_can_accept;
    logic               w_accept;
    logic               w_completion;
    logic               w_pop;
    logic [HART_W-1:0]  w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [OCC_W-1:0]   w_count;

    assign w_completion = mem_resp_valid_i || mem_ex_valid_i;
    assign w_pop        = w_completion && !w_fifo_empty;
    assign w_can_accept = (!r_stage_valid || mem_req_ready_i)
                          && ((w_count < OCC_W'(MAX_OUTSTANDING)) || w_pop);
    assign w_accept     = h_req_valid_i[w_grant] && w_can_accept;

    // Round-robin search: first valid hart at or after the pointer wins; if none
    // is valid the grant parks on the pointer.
    always_comb begin
        w_grant = r_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            w_idx = HART_W'((int'(r_ptr) + i) % NUM_HARTS);
            if (!w_found && h_req_valid_i[w_idx]) begin
                w_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Only the granted hart sees ready, and only when a slot and the stage are free.
    always_comb begin
        h_req_ready_o          = '0;
        h_req_ready_o[w_grant] = w_can_accept;
    end

    // Arbitration pointer advances past the winner only when a request is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= HART_W'((int'(w_grant) + 1) % NUM_HARTS);
        end
    end

    // Request stage: load on accept, hold while the harness stalls, empty on handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stage_valid <= 1'b0;
            r_stage_req   <= '0;
            r_stage_hart  <= '0;
        end else if (w_accept) begin
            r_stage_valid <= 1'b1;
            r_stage_req   <= h_req_i[w_grant];
            r_stage_hart  <= w_grant;
        end else if (r_stage_valid && mem_req_ready_i) begin
            r_stage_valid <= 1'b0;
        end
    end

    assign mem_req_valid_o = r_stage_valid;
    assign mem_req_o       = r_stage_req;
    assign mem_req_hart_o  = r_stage_hart;

    bridge_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (HART_W)
    ) u_tag_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_accept),
        .i_data  (w_grant),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    assign occupancy_o = w_count;

    // Completion routing to the oldest outstanding hart; exception beats response.
    always_comb begin
        h_resp_valid_o = '0;
        h_ex_valid_o   = '0;
        if (!w_fifo_empty) begin
            h_resp_valid_o[w_head] = mem_resp_valid_i && !mem_ex_valid_i;
            h_ex_valid_o[w_head]   = mem_ex_valid_i;
        end
    end

    assign h_resp_value_o   = mem_resp_value_i;
    assign h_ex_exception_o = mem_ex_exception_i;

    // Sticky flag for a completion that arrives with nothing outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_spurious <= 1'b0;
        end else if (w_completion && w_fifo_empty) begin
            r_err_spurious <= 1'b1;
        end
    end

    assign err_spurious_o = r_err_spurious;

`ifdef MUNTJAC_BRIDGE_PERF_EN
    logic [NUM_HARTS-1:0][31:0] r_perf_count;

    // Per-hart accepted-request counters, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_count <= '0;
        end else begin
            for (int g = 0; g < NUM_HARTS; g++) begin
                if (w_accept && (w_grant == HART_W'(g)) && (r_perf_count[g] != 32'hFFFF_FFFF)) begin
                    r_perf_count[g] <= r_perf_count[g] + 32'd1;
                end
            end
        end
    end

    assign perf_req_count_o = r_perf_count;
`endif

endmodule

// File: tb/tb_dcache_multi_hart_bridge.sv
// Directed self-checking bench for dcache_multi_hart_bridge (NUM_HARTS=2,
// MAX_OUTSTANDING=4). Inputs change 1ns after the rising edge and outputs are
// sampled away from the edge.
module tb_dcache_multi_hart_bridge;
    import muntjac_bridge_pkg::*;

    localparam int NH = 2;
    localparam int MO = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NH-1:0]                 h_req_valid;
    logic [NH-1:0]                 h_req_ready;
    dcache_bridge_req_t [NH-1:0]   h_req;
    logic [NH-1:0]                 h_resp_valid;
    logic [NH-1:0]                 h_ex_valid;
    logic [63:0]                   h_resp_value;
    exception_t                    h_ex_exception;
    logic                          mem_req_valid;
    logic                          mem_req_ready;
    dcache_bridge_req_t            mem_req;
    logic [0:0]                    mem_req_hart;
    logic                          mem_resp_valid;
    logic [63:0]                   mem_resp_value;
    logic                          mem_ex_valid;
    exception_t                    mem_ex;
    logic [2:0]                    occupancy;
    logic                          err_spurious;
`ifdef MUNTJAC_BRIDGE_PERF_EN
    logic [NH-1:0][31:0]           perf_req_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dcache_multi_hart_bridge #(
        .NUM_HARTS       (NH),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .h_req_valid_i      (h_req_valid),
        .h_req_ready_o      (h_req_ready),
        .h_req_i            (h_req),
        .h_resp_valid_o     (h_resp_valid),
        .h_ex_valid_o       (h_ex_valid),
        .h_resp_value_o     (h_resp_value),
        .h_ex_exception_o   (h_ex_exception),
        .mem_req_valid_o    (mem_req_valid),
        .mem_req_ready_i    (mem_req_ready),
        .mem_req_o          (mem_req),
        .mem_req_hart_o     (mem_req_hart),
        .mem_resp_valid_i   (mem_resp_valid),
        .mem_resp_value_i   (mem_resp_value),
        .mem_ex_valid_i     (mem_ex_valid),
        .mem_ex_exception_i (mem_ex),
        .occupancy_o        (occupancy),
        .err_spurious_o     (err_spurious)
`ifdef MUNTJAC_BRIDGE_PERF_EN
        ,
        .perf_req_count_o   (perf_req_count)
`endif
    );

    function automatic dcache_bridge_req_t makeReq(input logic [63:0] addr, input mem_op_e op);
        dcache_bridge_req_t r;
        r         = '0;
        r.address = addr;
        r.value   = ~addr;
        r.op      = op;
        r.size    = 2'd3;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        h_req_valid    = '0;
        h_req          = '0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_value = '0;
        mem_ex_valid   = 1'b0;
        mem_ex         = '0;
    endtask

    task automatic applyReset();
        clearInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_valid got=%b exp=0", mem_req_valid); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("[TB] FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (err_spurious !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err_spurious); end
        checks++; if (h_req_ready !== 2'b01) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=01", h_req_ready); end
        checks++; if (h_resp_valid !== 2'b00 || h_ex_valid !== 2'b00) begin failures++; $display("[TB] FAIL reset_hvalid got=%b/%b exp=00/00", h_resp_valid, h_ex_valid); end
    endtask

    task automatic test_single_load();
        applyReset();
        h_req[0]    = makeReq(64'h1000, MEM_LOAD);
        h_req_valid = 2'b01;
        #1;
        checks++; if (h_req_ready !== 2'b01) begin failures++; $display("[TB] FAIL single_ready got=%b exp=01", h_req_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_pre_valid got=%b exp=0", mem_req_valid); end
        tick();
        h_req_valid = '0;
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_mem_valid got=%b exp=1", mem_req_valid); end
        checks++; if (mem_req.address !== 64'h1000 || mem_req.op !== MEM_LOAD) begin failures++; $display("[TB] FAIL single_payload got=%h exp=1000", mem_req.address); end
        checks++; if (mem_req_hart !== 1'b0) begin failures++; $display("[TB] FAIL single_hart got=%0d exp=0", mem_req_hart); end
        checks++; if (occupancy !== 3'd1) begin failures++; $display("[TB] FAIL single_occ1 got=%0d exp=1", occupancy); end
        tick();
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_mem_clear got=%b exp=0", mem_req_valid); end
        mem_resp_valid = 1'b1;
        mem_resp_value = 64'hDEAD_BEEF;
        #1;
        checks++; if (h_resp_valid !== 2'b01) begin failures++; $display("[TB] FAIL single_resp_valid got=%b exp=01", h_resp_valid); end
        checks++; if (h_resp_value !== 64'hDEAD_BEEF) begin failures++; $display("[TB] FAIL single_resp_value got=%h exp=deadbeef", h_resp_value); end
        checks++; if (h_ex_valid !== 2'b00) begin failures++; $display("[TB] FAIL single_ex got=%b exp=00", h_ex_valid); end
        tick();
        mem_resp_valid = 1'b0;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("[TB] FAIL single_occ0 got=%0d exp=0", occupancy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] expReady;
        applyReset();
        h_req[0]    = makeReq(64'h2000, MEM_LOAD);
        h_req[1]    = makeReq(64'h3000, MEM_STORE);
        h_req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            expReady = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (h_req_ready !== expReady) begin failures++; $display("[TB] FAIL rr_ready[%0d] got=%b exp=%b", i, h_req_ready, expReady); end
            tick();
            checks++; if (mem_req_hart !== 1'(i % 2)) begin failures++; $display("[TB] FAIL rr_hart[%0d] got=%0d exp=%0d", i, mem_req_hart, i % 2); end
        end
        h_req_valid = '0;
        checks++; if (occupancy !== 3'd4) begin failures++; $display("[TB] FAIL rr_occ_full got=%0d exp=4", occupancy); end
        mem_resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expReady = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (h_resp_valid !== expReady) begin failures++; $display("[TB] FAIL rr_route[%0d] got=%b exp=%b", i, h_resp_valid, expReady); end
            tick();
        end
        mem_resp_valid = 1'b0;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("[TB] FAIL rr_occ_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_full();
        applyReset();
        h_req[0]    = makeReq(64'h4000, MEM_LOAD);
        h_req_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (occupancy !== 3'(i + 1)) begin failures++; $display("[TB] FAIL full_occ[%0d] got=%0d exp=%0d", i, occupancy, i + 1); end
        end
        #1;
        checks++; if (h_req_ready !== 2'b00) begin failures++; $display("[TB] FAIL full_blocked got=%b exp=00", h_req_ready); end
        mem_resp_valid = 1'b1;
        #1;
        checks++; if (h_req_ready !== 2'b01) begin failures++; $display("[TB] FAIL full_pop_ready got=%b exp=01", h_req_ready); end
        checks++; if (h_resp_valid !== 2'b01) begin failures++; $display("[TB] FAIL full_pop_route got=%b exp=01", h_resp_valid); end
        tick();
        h_req_valid = '0;
        checks++; if (occupancy !== 3'd4) begin failures++; $display("[TB] FAIL full_push_pop_occ got=%0d exp=4", occupancy); end
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_push_pop_valid got=%b exp=1", mem_req_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        mem_resp_valid = 1'b0;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("[TB] FAIL full_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_exception_routing();
        applyReset();
        h_req[0]    = makeReq(64'h5000, MEM_LOAD);
        h_req[1]    = makeReq(64'h6000, MEM_AMO);
        h_req_valid = 2'b01;
        tick();
        h_req_valid = 2'b10;
        tick();
        h_req_valid = '0;
        mem_ex_valid = 1'b1;
        mem_ex.cause = 4'd5;
        mem_ex.tval  = 64'hBAD;
        #1;
        checks++; if (h_ex_valid !== 2'b01) begin failures++; $display("[TB] FAIL ex_first got=%b exp=01", h_ex_valid); end
        checks++; if (h_resp_valid !== 2'b00) begin failures++; $display("[TB] FAIL ex_first_resp got=%b exp=00", h_resp_valid); end
        checks++; if (h_ex_exception.cause !== 4'd5 || h_ex_exception.tval !== 64'hBAD) begin failures++; $display("[TB] FAIL ex_payload got=%0d/%h exp=5/bad", h_ex_exception.cause, h_ex_exception.tval); end
        tick();
        mem_ex_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_value = 64'h1234;
        #1;
        checks++; if (h_resp_valid !== 2'b10) begin failures++; $display("[TB] FAIL ex_second_resp got=%b exp=10", h_resp_valid); end
        checks++; if (h_ex_valid !== 2'b00) begin failures++; $display("[TB] FAIL ex_second_ex got=%b exp=00", h_ex_valid); end
        tick();
        mem_resp_valid = 1'b0;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("[TB] FAIL ex_occ0 got=%0d exp=0", occupancy); end
        h_req_valid = 2'b11;
        tick();
        tick();
        h_req_valid = '0;
        checks++; if (occupancy !== 3'd2) begin failures++; $display("[TB] FAIL both_occ2 got=%0d exp=2", occupancy); end
        mem_resp_valid = 1'b1;
        mem_ex_valid   = 1'b1;
        #1;
        checks++; if (h_ex_valid !== 2'b01 || h_resp_valid !== 2'b00) begin failures++; $display("[TB] FAIL both_ex_wins got=%b/%b exp=01/00", h_ex_valid, h_resp_valid); end
        tick();
        mem_ex_valid = 1'b0;
        checks++; if (occupancy !== 3'd1) begin failures++; $display("[TB] FAIL both_single_pop got=%0d exp=1", occupancy); end
        #1;
        checks++; if (h_resp_valid !== 2'b10) begin failures++; $display("[TB] FAIL both_next_resp got=%b exp=10", h_resp_valid); end
        tick();
        mem_resp_valid = 1'b0;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("[TB] FAIL both_occ0 got=%0d exp=0", occupancy); end
    endtask

    task automatic test_spurious();
        applyReset();
        mem_resp_valid = 1'b1;
        #1;
        checks++; if (h_resp_valid !== 2'b00 || h_ex_valid !== 2'b00) begin failures++; $display("[TB] FAIL spur_route got=%b/%b exp=00/00", h_resp_valid, h_ex_valid); end
        tick();
        mem_resp_valid = 1'b0;
        checks++; if (err_spurious !== 1'b1) begin failures++; $display("[TB] FAIL spur_err got=%b exp=1", err_spurious); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("[TB] FAIL spur_occ got=%0d exp=0", occupancy); end
        tick();
        tick();
        checks++; if (err_spurious !== 1'b1) begin failures++; $display("[TB] FAIL spur_sticky got=%b exp=1", err_spurious); end
    endtask

    task automatic test_stall_reset();
        applyReset();
        checks++; if (err_spurious !== 1'b0) begin failures++; $display("[TB] FAIL stall_err_cleared got=%b exp=0", err_spurious); end
        mem_req_ready = 1'b0;
        h_req[1]      = makeReq(64'h7000, MEM_STORE);
        h_req_valid   = 2'b10;
        #1;
        checks++; if (h_req_ready !== 2'b10) begin failures++; $display("[TB] FAIL stall_first_ready got=%b exp=10", h_req_ready); end
        tick();
        h_req[1]    = makeReq(64'h7777, MEM_LOAD);
        h_req[0]    = makeReq(64'h8000, MEM_LOAD);
        h_req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (h_req_ready !== 2'b00) begin failures++; $display("[TB] FAIL stall_ready[%0d] got=%b exp=00", i, h_req_ready); end
            checks++; if (mem_req_valid !== 1'b1 || mem_req.address !== 64'h7000 || mem_req_hart !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold[%0d] got=%b/%h/%0d exp=1/7000/1", i, mem_req_valid, mem_req.address, mem_req_hart); end
            checks++; if (occupancy !== 3'd1) begin failures++; $display("[TB] FAIL stall_occ[%0d] got=%0d exp=1", i, occupancy); end
            tick();
        end
        h_req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_req_ready = 1'b1;
        checks++; if (mem_req_valid !== 1'b0 || mem_req.address !== 64'h0 || mem_req_hart !== 1'b0) begin failures++; $display("[TB] FAIL rst_stage got=%b/%h/%0d exp=0/0/0", mem_req_valid, mem_req.address, mem_req_hart); end
        checks++; if (occupancy !== 3'd0 || err_spurious !== 1'b0) begin failures++; $display("[TB] FAIL rst_occ_err got=%0d/%b exp=0/0", occupancy, err_spurious); end
        checks++; if (h_resp_valid !== 2'b00 || h_ex_valid !== 2'b00) begin failures++; $display("[TB] FAIL rst_hvalid got=%b/%b exp=00/00", h_resp_valid, h_ex_valid); end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        rst = 1'b1;
        clearInputs();
        test_reset();
        test_single_load();
        test_round_robin();
        test_full();
        test_exception_routing();
        test_spurious();
        test_stall_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
